// File: rtl/pipelined_aba_adder_if.sv
// Handshake bundle for pipelined_aba_adder: operand/mode input side and
// sum/carry output side, each with its own valid/ready pair.
interface pipelined_aba_adder_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic             approx_en;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, approx_en, cin, a, b, out_ready,
    input  in_ready, out_valid, s, cout
  );

  // Adder side.
  modport slave (
    input  in_valid, approx_en, cin, a, b, out_ready,
    output in_ready, out_valid, s, cout
  );
endinterface

// File: rtl/pipelined_aba_adder.sv
// Pipelined approximate/exact adder. The low APPROX_WIDTH bits are either an
// exact small add or a copy of a[APPROX_WIDTH-1]; the remaining bits are split
// into NSEG carry-lookahead segments, one register stage per segment, with the
// carry and the not-yet-used operand bits carried forward between stages.

// One carry-lookahead segment: flat generate/propagate carry terms.
module aba_cla_seg #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c,
  output logic [W-1:0] o_s,
  output logic         o_c
);
  logic [W-1:0] w_g;
  logic [W-1:0] w_p;
  logic [W:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded per bit
  always_comb begin
    logic pp;
    logic cc;
    w_c    = '0;
    w_c[0] = i_c;
    for (int i = 0; i < W; i++) begin
      pp = 1'b1;
      cc = w_g[i];
      for (int j = i; j > 0; j--) begin
        pp = pp & w_p[j];
        cc = cc | (pp & w_g[j-1]);
      end
      pp = pp & w_p[0];
      cc = cc | (pp & i_c);
      w_c[i+1] = cc;
    end
  end

  assign o_s = w_p ^ w_c[W-1:0];
  assign o_c = w_c[W];
endmodule

module pipelined_aba_adder #(
  parameter int WIDTH        = 12,
  parameter int LCA_WIDTH    = 4,
  parameter int APPROX_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_aba_adder_if.slave  bus
);
  localparam int AW   = APPROX_WIDTH;
  localparam int L    = LCA_WIDTH;
  localparam int NSEG = (WIDTH - APPROX_WIDTH) / LCA_WIDTH;

  if (APPROX_WIDTH < 1 || LCA_WIDTH < 1 || WIDTH <= APPROX_WIDTH ||
      ((WIDTH - APPROX_WIDTH) % LCA_WIDTH) != 0) begin : g_bad_params
    $error("pipelined_aba_adder: illegal WIDTH/LCA_WIDTH/APPROX_WIDTH combination");
  end

  // Whole pipe freezes while the output holds an unconsumed result.
  logic w_stall;
  logic w_adv;
  assign w_stall      = bus.out_valid & ~bus.out_ready;
  assign w_adv        = ~w_stall;
  assign bus.in_ready = w_adv;

  logic [AW:0]   w_low_exact;
  logic [AW-1:0] w_low_sum;
  logic          w_low_c;

  // Low region: exact small add, or replicate a[AW-1] and feed it as carry
  always_comb begin
    w_low_exact = {1'b0, bus.a[AW-1:0]} + {1'b0, bus.b[AW-1:0]} + (AW+1)'(bus.cin);
    w_low_sum   = w_low_exact[AW-1:0];
    w_low_c     = w_low_exact[AW];
    if (bus.approx_en) begin
      w_low_sum = {AW{bus.a[AW-1]}};
      w_low_c   = bus.a[AW-1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : st
    localparam int LO = AW + k * L;   // lowest bit handled by this segment
    localparam int UW = WIDTH - LO;   // operand bits still pending at entry

    logic [UW-1:0] w_ua;
    logic [UW-1:0] w_ub;
    logic [LO-1:0] w_lsum;
    logic          w_ci;
    logic          w_vi;
    logic [L-1:0]  w_s;
    logic          w_co;

    logic          r_vld;
    logic          r_c;
    logic [LO+L-1:0] r_sum;

    if (k == 0) begin : g_src
      assign w_ua   = bus.a[WIDTH-1:LO];
      assign w_ub   = bus.b[WIDTH-1:LO];
      assign w_lsum = w_low_sum;
      assign w_ci   = w_low_c;
      assign w_vi   = bus.in_valid;
    end else begin : g_src
      assign w_ua   = st[k-1].g_ops.r_ua;
      assign w_ub   = st[k-1].g_ops.r_ub;
      assign w_lsum = st[k-1].r_sum;
      assign w_ci   = st[k-1].r_c;
      assign w_vi   = st[k-1].r_vld;
    end

    aba_cla_seg #(.W(L)) u_seg (
      .i_a (w_ua[L-1:0]),
      .i_b (w_ub[L-1:0]),
      .i_c (w_ci),
      .o_s (w_s),
      .o_c (w_co)
    );

    // Stage k result: valid, segment carry-out, all sum bits completed so far
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_vld <= w_vi;
        r_c   <= w_co;
        r_sum <= {w_s, w_lsum};
      end
    end

    if (k < NSEG - 1) begin : g_ops
      logic [UW-L-1:0] r_ua;
      logic [UW-L-1:0] r_ub;

      // Skewed operand bits for the segments still ahead
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ua <= '0;
          r_ub <= '0;
        end else if (w_adv) begin
          r_ua <= w_ua[UW-1:L];
          r_ub <= w_ub[UW-1:L];
        end
      end
    end
  end

  assign bus.out_valid = st[NSEG-1].r_vld;
  assign bus.s         = st[NSEG-1].r_sum;
  assign bus.cout      = st[NSEG-1].r_c;
endmodule

// File: doc/pipelined_aba_adder.md
Name: pipelined_aba_adder

Overview:
- Parametrised, pipelined successor to the team's fixed 12-bit approximate lower-part adder, used in the Gaussian FIR filter datapath.
- Splits the operands into an approximate low region plus N exact 4-bit lookahead-carry segments, with one register stage per segment. This carry-pipelining lets wide accumulations close timing.
- A per-transaction mode bit selects approximate or exact addition.
- Valid/ready handshake on both sides, with full back-pressure stall.

Parameters:
- WIDTH, 12, operand and sum width.
- LCA_WIDTH, 4, bits per exact carry-lookahead segment.
- APPROX_WIDTH, 4, width of the low approximate region. Must be ≥1. (WIDTH-APPROX_WIDTH) must be a positive multiple of LCA_WIDTH.
- NSEG, (WIDTH-APPROX_WIDTH)/LCA_WIDTH, derived localparam: segment count, which equals the latency.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input this cycle.
- approx_en  in  1  1 = approximate mode, 0 = exact mode; sampled with the operands.
- cin  in  1  carry-in; used in exact mode only.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  sum.
- cout  out  1  carry-out of the MSB segment.

Behaviour:
- Handshake:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - While stalled, every pipeline register, including valid bits, holds.
  - When not stalled, the pipeline advances one stage per cycle; bubbles (valid=0) propagate.
- Latency: exactly NSEG cycles from acceptance to out_valid, when no stall occurs. Throughput is 1 per cycle.
- Ordering: strictly in order; no drop or duplicate under any stall pattern.
- Approximate mode (approx_en=1):
  - s[APPROX_WIDTH-1:0] = all bits equal to a[APPROX_WIDTH-1].
  - Carry into segment 0 = a[APPROX_WIDTH-1].
  - cin is ignored.
- Exact mode (approx_en=0):
  - Low region computed as a[APPROX_WIDTH-1:0] + b[APPROX_WIDTH-1:0] + cin.
  - Its carry-out feeds segment 0.
  - Result equals the full (WIDTH+1)-bit sum {cout,s} = a+b+cin.
- Segments: segment k covers bits [APPROX_WIDTH+(k+1)*LCA_WIDTH-1 : APPROX_WIDTH+k*LCA_WIDTH] and is computed in pipeline stage k.
  - Stage 0 computes the low region plus segment 0.
  - Stage k registers: the segment-k sum, the carry out of segment k, and all completed lower sum bits.
  - Unprocessed upper operand bits travel skewed alongside each stage.
  - The mode bit does not need to travel; it only affects stage 0.
- Carry arithmetic is modulo 2^WIDTH on s; overflow is reported only via cout. No saturation.
- Reset (rst_n=0, asynchronous): all stage valid bits = 0, out_valid=0, s=0, cout=0, all data registers = 0.
  - Reset mid-operation discards in-flight transactions.
  - in_ready = 1 during and after reset.
- Simultaneous accept and output consume in the same cycle: both occur.
- Elaboration fails if the parameter constraints are violated.

Test Plan:
- All cases below use defaults, so NSEG=2.
- Approximate add: a=0x0F8, b=0x010, approx_en=1, out_ready=1 → s=0x11F, cout=0, out_valid exactly 2 cycles after accept.
- Exact add: same operands, approx_en=0, cin=0 → s=0x108, cout=0. Repeat with cin=1 → s=0x109.
- Wrap/overflow, exact: a=0xFFF, b=0x001, cin=0 → s=0x000, cout=1. Approximate: → s=0x00F, cout=1.
- Back-to-back with stall: stream 8 accepts with random modes; hold out_ready=0 for 3 cycles mid-stream.
  - in_ready drops the same cycle stall asserts.
  - Results match the reference model in order, no loss.
  - out_valid/s stable while stalled.
- Reset mid-flight: accept 2 transactions, pull rst_n low asynchronously between edges → out_valid=0, s=0 immediately. After release, no stale result appears; a new a=0x001, b=0x001 exact → s=0x002.
- Parameter sweep: WIDTH=16, APPROX_WIDTH=4 (NSEG=3) and WIDTH=8, APPROX_WIDTH=4 (NSEG=1). Random exact-mode vectors → {cout,s}=a+b+cin, latency = NSEG.
